// File: rtl/mvm_pkg.sv
// Shared constants, state type and diagonal decode for the mvm array feeder.
package mvm_pkg;

   localparam int unsigned DATA_WIDTH_DEF = 32;
   localparam int unsigned NUM_DIAG       = 7;
   localparam int unsigned ARR_N          = 4;

   typedef enum logic [1:0] {IDLE, RUN, FIN} feed_state_e;

   // Highest set bit of the diagonal enable vector; 0 when no bit is set.
   function automatic logic [2:0] diag_index(input logic [NUM_DIAG-1:0] en);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < int'(NUM_DIAG); i++) begin
         if (en[i]) idx = 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/diag_weight_mux.sv
// Selects, for each array column c, the weight W[d-c][c] of the active diagonal d.
module diag_weight_mux
   import mvm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                                        en,
   input  logic [2:0]                                  d,
   input  logic [ARR_N-1:0][ARR_N-1:0][DATA_WIDTH-1:0] w_bank,
   output logic [ARR_N-1:0][DATA_WIDTH-1:0]            w_out
);

   logic [1:0] ci;
   logic [3:0] diff;

   always_comb begin
      w_out = '0;
      ci    = 2'd0;
      diff  = 4'd0;
      for (int c = 0; c < int'(ARR_N); c++) begin
         ci   = 2'(c);
         diff = {1'b0, d} - {2'b00, ci};
         // diff[3] set means d < c; diff[2] set means row beyond the array
         if (en && (diff[3:2] == 2'b00)) begin
            w_out[c] = w_bank[diff[1:0]][ci];
         end
      end
   end

endmodule

// File: rtl/mvm_feeder.sv
// Operand sequencer for the 4x4 systolic mvm array: stores vector and weights,
// runs start/done handshake with timeout, and steers operands per active diagonal.
module mvm_feeder
   import mvm_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned TIMEOUT    = 64,
   parameter int unsigned TO_W       = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  vec_wr_en,
   input  logic [1:0]            vec_addr,
   input  logic [DATA_WIDTH-1:0] vec_wdata,
   input  logic                  w_wr_en,
   input  logic [1:0]            w_row,
   input  logic [1:0]            w_col,
   input  logic [DATA_WIDTH-1:0] w_wdata,
   input  logic                  go,
   output logic                  busy,
   output logic                  feed_done,
   output logic                  timeout_err,
   output logic                  wr_err,
   output logic                  start,
   output logic [1:0]            data_sel,
   output logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] weight_1,
   output logic [DATA_WIDTH-1:0] weight_2,
   output logic [DATA_WIDTH-1:0] weight_3,
   output logic [DATA_WIDTH-1:0] weight_4,
   input  logic [NUM_DIAG-1:0]   en_diag_in,
   input  logic                  mvm_done
);

   feed_state_e                                 state_q;
   logic [TO_W-1:0]                             to_q;
   logic                                        start_q, busy_q, feed_done_q;
   logic                                        timeout_err_q, wr_err_q;
   logic [ARR_N-1:0][DATA_WIDTH-1:0]            vec_q;
   logic [ARR_N-1:0][ARR_N-1:0][DATA_WIDTH-1:0] w_q;
   logic [ARR_N-1:0][DATA_WIDTH-1:0]            w_steer;
   logic [2:0]                                  d;
   logic                                        steer_en;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         to_q          <= '0;
         start_q       <= 1'b0;
         busy_q        <= 1'b0;
         feed_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         wr_err_q      <= 1'b0;
      end else begin
         feed_done_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         wr_err_q      <= (vec_wr_en | w_wr_en) && (state_q != IDLE);
         unique case (state_q)
            IDLE: begin
               to_q <= '0;
               if (go) begin
                  state_q <= RUN;
                  start_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            RUN: begin
               // mvm_done takes priority over an expiring timeout
               if (mvm_done) begin
                  state_q     <= FIN;
                  start_q     <= 1'b0;
                  feed_done_q <= 1'b1;
               end else if (to_q == TO_W'(TIMEOUT - 1)) begin
                  state_q       <= IDLE;
                  start_q       <= 1'b0;
                  busy_q        <= 1'b0;
                  timeout_err_q <= 1'b1;
                  to_q          <= '0;
               end else if (to_q != {TO_W{1'b1}}) begin
                  to_q <= to_q + TO_W'(1);
               end
            end
            FIN: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               to_q    <= '0;
            end
            default: begin
               state_q <= IDLE;
               start_q <= 1'b0;
               busy_q  <= 1'b0;
               to_q    <= '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vec_q <= '0;
         w_q   <= '0;
      end else if (state_q == IDLE) begin
         if (vec_wr_en) vec_q[vec_addr] <= vec_wdata;
         if (w_wr_en) w_q[w_row][w_col] <= w_wdata;
      end
   end

   assign d        = diag_index(en_diag_in);
   assign steer_en = start_q && (|en_diag_in);

   always_comb begin
      data_sel = 2'd0;
      data_in  = '0;
      if (steer_en) begin
         data_sel = d[2] ? 2'd3 : d[1:0];
         if (!d[2]) data_in = vec_q[d[1:0]];
      end
   end

   diag_weight_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_diag_weight_mux (
      .en     (steer_en),
      .d      (d),
      .w_bank (w_q),
      .w_out  (w_steer)
   );

   assign weight_1    = w_steer[0];
   assign weight_2    = w_steer[1];
   assign weight_3    = w_steer[2];
   assign weight_4    = w_steer[3];
   assign start       = start_q;
   assign busy        = busy_q;
   assign feed_done   = feed_done_q;
   assign timeout_err = timeout_err_q;
   assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_mvm_feeder.sv
// Directed bench for mvm_feeder: diagonal steering table plus handshake, timeout,
// write-reject and asynchronous reset sequences.
module tb_mvm_feeder;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          vec_wr_en, w_wr_en, go, mvm_done;
   logic [1:0]    vec_addr, w_row, w_col;
   logic [DW-1:0] vec_wdata, w_wdata;
   logic          busy, feed_done, timeout_err, wr_err, start;
   logic [1:0]    data_sel;
   logic [DW-1:0] data_in, weight_1, weight_2, weight_3, weight_4;
   logic [6:0]    en_diag_in;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mvm_feeder dut (
      .clk         (clk),
      .rst         (rst),
      .vec_wr_en   (vec_wr_en),
      .vec_addr    (vec_addr),
      .vec_wdata   (vec_wdata),
      .w_wr_en     (w_wr_en),
      .w_row       (w_row),
      .w_col       (w_col),
      .w_wdata     (w_wdata),
      .go          (go),
      .busy        (busy),
      .feed_done   (feed_done),
      .timeout_err (timeout_err),
      .wr_err      (wr_err),
      .start       (start),
      .data_sel    (data_sel),
      .data_in     (data_in),
      .weight_1    (weight_1),
      .weight_2    (weight_2),
      .weight_3    (weight_3),
      .weight_4    (weight_4),
      .en_diag_in  (en_diag_in),
      .mvm_done    (mvm_done)
   );

   typedef struct {
      logic [6:0]    en;
      logic [1:0]    sel;
      logic [DW-1:0] din;
      logic [DW-1:0] w1;
      logic [DW-1:0] w2;
      logic [DW-1:0] w3;
      logic [DW-1:0] w4;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_steer(input string tag, input logic [1:0] sel, input logic [DW-1:0] din,
                            input logic [DW-1:0] w1, input logic [DW-1:0] w2,
                            input logic [DW-1:0] w3, input logic [DW-1:0] w4);
      chk({tag, ".data_sel"}, 64'(data_sel), 64'(sel));
      chk({tag, ".data_in"}, 64'(data_in), 64'(din));
      chk({tag, ".weight_1"}, 64'(weight_1), 64'(w1));
      chk({tag, ".weight_2"}, 64'(weight_2), 64'(w2));
      chk({tag, ".weight_3"}, 64'(weight_3), 64'(w3));
      chk({tag, ".weight_4"}, 64'(weight_4), 64'(w4));
   endtask

   initial begin
      int n;
      // vec = {1,2,3,4}, W[r][c] = 10*r + c
      tbl[0] = '{7'b0000001, 2'd0, 32'd1, 32'd0,  32'd0,  32'd0,  32'd0};
      tbl[1] = '{7'b0000010, 2'd1, 32'd2, 32'd10, 32'd1,  32'd0,  32'd0};
      tbl[2] = '{7'b0000100, 2'd2, 32'd3, 32'd20, 32'd11, 32'd2,  32'd0};
      tbl[3] = '{7'b0001000, 2'd3, 32'd4, 32'd30, 32'd21, 32'd12, 32'd3};
      tbl[4] = '{7'b0010000, 2'd3, 32'd0, 32'd0,  32'd31, 32'd22, 32'd13};
      tbl[5] = '{7'b0100000, 2'd3, 32'd0, 32'd0,  32'd0,  32'd32, 32'd23};
      tbl[6] = '{7'b1000000, 2'd3, 32'd0, 32'd0,  32'd0,  32'd0,  32'd33};
      tbl[7] = '{7'b0000101, 2'd2, 32'd3, 32'd20, 32'd11, 32'd2,  32'd0};
      tbl[8] = '{7'b1001011, 2'd3, 32'd0, 32'd0,  32'd0,  32'd0,  32'd33};
      tbl[9] = '{7'b0000000, 2'd0, 32'd0, 32'd0,  32'd0,  32'd0,  32'd0};

      rst = 1'b1;
      vec_wr_en = 0; w_wr_en = 0; go = 0; mvm_done = 0;
      vec_addr = 0; w_row = 0; w_col = 0; vec_wdata = 0; w_wdata = 0;
      en_diag_in = 7'b0001000;
      #12;
      chk("rst.start", 64'(start), 64'd0);
      chk("rst.busy", 64'(busy), 64'd0);
      chk("rst.feed_done", 64'(feed_done), 64'd0);
      chk("rst.timeout_err", 64'(timeout_err), 64'd0);
      chk("rst.wr_err", 64'(wr_err), 64'd0);
      chk_steer("rst", 2'd0, '0, '0, '0, '0, '0);
      rst = 1'b0;
      step();

      // Load banks; vector and weight writes overlap, last weight write coincides with go
      for (int i = 0; i < 16; i++) begin
         w_wr_en = 1'b1;
         w_row   = 2'(i / 4);
         w_col   = 2'(i % 4);
         w_wdata = DW'(10 * (i / 4) + (i % 4));
         vec_wr_en = (i < 4);
         vec_addr  = 2'(i % 4);
         vec_wdata = DW'(i + 1);
         go        = (i == 15);
         chk("idle.steer_off", 64'(weight_4), 64'd0);
         step();
      end
      w_wr_en = 0; vec_wr_en = 0; go = 0;
      chk("load.wr_err", 64'(wr_err), 64'd0);
      chk("go.start", 64'(start), 64'd1);
      chk("go.busy", 64'(busy), 64'd1);

      for (int i = 0; i < 10; i++) begin
         en_diag_in = tbl[i].en;
         #1;
         chk_steer($sformatf("tbl[%0d]", i), tbl[i].sel, tbl[i].din,
                   tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].w4);
      end

      // Rejected write during RUN; go in RUN is ignored
      vec_wr_en = 1; vec_addr = 0; vec_wdata = 99; go = 1;
      step();
      vec_wr_en = 0; go = 0;
      chk("run_wr.wr_err", 64'(wr_err), 64'd1);
      chk("run_wr.start", 64'(start), 64'd1);
      step();
      chk("run_wr.wr_err_clear", 64'(wr_err), 64'd0);

      for (int i = 0; i < 17; i++) step();
      chk("pre_done.start", 64'(start), 64'd1);
      mvm_done = 1;
      step();
      mvm_done = 0;
      chk("fin.start", 64'(start), 64'd0);
      chk("fin.feed_done", 64'(feed_done), 64'd1);
      chk("fin.busy", 64'(busy), 64'd1);
      step();
      chk("post_fin.feed_done", 64'(feed_done), 64'd0);
      chk("post_fin.busy", 64'(busy), 64'd0);

      // Timeout run; also confirms vector element 0 survived the rejected write
      go = 1;
      step();
      go = 0;
      en_diag_in = 7'b0000001;
      #1;
      chk("keep.data_in", 64'(data_in), 64'd1);
      n = 1;
      while (start && n < 100) begin
         step();
         if (start) n++;
      end
      chk("timeout.run_cycles", 64'(n), 64'd64);
      chk("timeout.err", 64'(timeout_err), 64'd1);
      chk("timeout.busy", 64'(busy), 64'd0);
      chk("timeout.done", 64'(feed_done), 64'd0);
      step();
      chk("timeout.err_clear", 64'(timeout_err), 64'd0);

      // mvm_done and timeout in the same cycle: done wins
      go = 1;
      step();
      go = 0;
      chk("go2.start", 64'(start), 64'd1);
      for (int i = 0; i < 63; i++) step();
      mvm_done = 1;
      step();
      mvm_done = 0;
      chk("tie.feed_done", 64'(feed_done), 64'd1);
      chk("tie.timeout_err", 64'(timeout_err), 64'd0);
      step();

      // Asynchronous reset mid-run
      go = 1;
      step();
      go = 0;
      en_diag_in = 7'b0001000;
      #1;
      chk_steer("pre_rst", 2'd3, 32'd4, 32'd30, 32'd21, 32'd12, 32'd3);
      #2;
      rst = 1'b1;
      #1;
      chk("arst.start", 64'(start), 64'd0);
      chk("arst.busy", 64'(busy), 64'd0);
      chk_steer("arst", 2'd0, '0, '0, '0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      step();
      go = 1;
      step();
      go = 0;
      #1;
      chk_steer("post_rst", 2'd3, '0, '0, '0, '0, '0);
      mvm_done = 1;
      step();
      mvm_done = 0;
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mvm_feeder.md
Name: mvm_feeder

Overview:
- Operand sequencer that drives the 4x4 systolic mvm array. It is the transmitter side of the array's start/data_sel/data_in/weight_1..4 interface.
- Holds one 4-element input vector and one 4x4 weight matrix, both loaded from the host through simple write ports.
- On a go command it asserts start, then steers the vector element and weights that match the array's currently active diagonal (en_diag_in).
- Ends the run when the array reports done, or when a timeout expires.

Parameters:
DATA_WIDTH, 32, width of vector elements and weights
TIMEOUT, 64, maximum RUN cycles to wait for mvm_done before aborting
TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
vec_wr_en  in  1  write vector element
vec_addr  in  2  vector index 0..3
vec_wdata  in  DATA_WIDTH  vector element
w_wr_en  in  1  write weight
w_row  in  2  weight row 0..3 (array row)
w_col  in  2  weight column 0..3 (array column)
w_wdata  in  DATA_WIDTH  weight value
go  in  1  start-run pulse
busy  out  1  run in progress
feed_done  out  1  one-cycle pulse on normal completion
timeout_err  out  1  one-cycle pulse on timeout abort
wr_err  out  1  one-cycle pulse when a write is rejected
start  out  1  to the array's start input
data_sel  out  2  to the array's data_sel input
data_in  out  DATA_WIDTH  to the array's data_in input
weight_1..weight_4  out  DATA_WIDTH each  to array columns 1..4
en_diag_in  in  7  en_diag0..6 from the array; bit d is diagonal d
mvm_done  in  1  done from the array

Behaviour:

Reset:
- Reset is asynchronous, active-high, and may arrive at any time, including mid-run.
- Reset clears the vector and weight banks to 0 and sets state to IDLE.
- While in reset, all outputs are 0.

States:
- IDLE:
  - start=0, busy=0.
  - go -> RUN on the next edge; start=1 and busy=1 from that edge.
- RUN:
  - start=1, busy=1, and the timeout counter increments each cycle.
  - mvm_done=1 -> FIN.
  - If the counter reaches TIMEOUT-1 without mvm_done, go to IDLE: start drops, timeout_err pulses for 1 cycle, counter clears.
  - mvm_done and the timeout condition in the same cycle: mvm_done wins.
- FIN:
  - start=0, feed_done=1, busy=1, held for exactly 1 cycle, then IDLE.
  - The counter clears here.

Command rules:
- go is ignored when not in IDLE; no error is flagged.

Write rules:
- Writes are accepted only in IDLE and take effect at the next edge.
- A write (vec_wr_en or w_wr_en) in RUN or FIN is dropped, and wr_err pulses the following cycle.
- Simultaneous vector and weight writes in IDLE are both accepted.
- go and a write in the same IDLE cycle: the write is accepted and the run sees the new value.

Operand steering (combinational from en_diag_in and stored banks; zero latency):
- Steering is active only while start=1; otherwise data_sel, data_in and weight_1..4 are 0.
- Diagonal index d is the highest set bit of en_diag_in.
- No bit set: all steered outputs are 0, data_sel=0.
- data_sel = min(d,3).
- data_in = vec[d] for d<=3, else 0.
- weight_{c+1} for c=0..3: let r=d-c. If 0<=r<=3 the output is W[r][c], otherwise 0.

Arithmetic:
- No arithmetic on data; values pass through unmodified.
- The counter saturates and does not wrap.

Decomposition:
- Shared package mvm_pkg:
  - DATA_WIDTH default
  - diagonal count constant NUM_DIAG=7
  - array dimension ARR_N=4
  - feeder state enum {IDLE, RUN, FIN}
- One natural sub-module: diag_weight_mux. It takes d plus the flat weight bank and produces weight_1..4 by the r=d-c rule; it is instantiated once.

Test Plan:
1. Load vec={1,2,3,4}, W[r][c]=10*r+c. Pulse go, drive en_diag_in=7'b0000100 -> data_sel=2, data_in=3, weight_1=20, weight_2=11, weight_3=2, weight_4=0.
2. Same load, en_diag_in=7'b0100000 (d=5) -> data_sel=3, data_in=0, weight_1=0, weight_2=0, weight_3=32, weight_4=23.
3. go, then mvm_done=1 after 20 cycles -> start falls on the next edge, feed_done pulses exactly 1 cycle, busy=0 on the cycle after.
4. go, mvm_done held 0 -> timeout_err pulses at RUN cycle 64, start=0, state IDLE. A second go then starts normally.
5. During RUN, write vec_addr=0 with 99 -> wr_err pulses 1 cycle. After the run, vector element 0 still reads 1 at d=0.
6. Assert rst mid-RUN with en_diag_in=7'b0001000 -> start, busy, weights and data_in go to 0 immediately (asynchronous); banks read 0 after release.
